// File: rtl/lcd1602_writer.sv
// lcd1602_writer: FIFO-buffered HD44780 (LCD1602) write sequencer with busy/full/overflow status.
// Define LCD1602_4BIT_EN to run each entry as two nibble transfers on lcd_d[7:4].
module lcd1602_writer #(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 4,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 320,
  parameter int LONG_WAIT_CYC = 13000
) (
  input  logic       in_clock,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       clr_ovf,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_d,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);

  localparam int PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_C > LONG_WAIT_CYC) ? MAX_C : LONG_WAIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   FCNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FCNT_ZERO = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]   FCNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EHI    = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EHI   = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  logic [8:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_fcount;
  logic [PTR_W:0]   w_fcount_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_busy;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic             w_full_nxt;
  logic             w_empty_nxt;
  logic [8:0]       w_head;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_zero;
  logic             r_e;
  logic             w_e_nxt;
  logic             r_rs;
  logic             w_rs_nxt;
  logic [7:0]       r_d;
  logic [7:0]       w_d_nxt;
  logic [7:0]       r_byte;
  logic [7:0]       w_byte_nxt;
`ifdef LCD1602_4BIT_EN
  logic             r_nib;
  logic             w_nib_nxt;
`endif

  // Clear-display and return-home need the long execution wait.
  function automatic logic [CNT_W-1:0] wait_load(input logic rs, input logic [7:0] b);
    if (!rs && (b[7:2] == 6'd0)) begin
      wait_load = CNT_W'(LONG_WAIT_CYC - 1);
    end else begin
      wait_load = CNT_W'(CMD_WAIT_CYC - 1);
    end
  endfunction

  // First bus lane of a byte: the whole byte, or its high nibble in 4-bit mode.
  function automatic logic [7:0] first_lane(input logic [7:0] b);
`ifdef LCD1602_4BIT_EN
    first_lane = {b[7:4], 4'h0};
`else
    first_lane = b;
`endif
  endfunction

  assign w_head = r_mem[r_rd_ptr];

  // FIFO push/drop decode and next occupancy; full test uses the registered flag.
  always_comb begin
    w_push = wr_stb & ~r_full;
    w_drop = wr_stb & r_full;
    case ({w_push, w_pop})
      2'b10:   w_fcount_nxt = r_fcount + FCNT_ONE;
      2'b01:   w_fcount_nxt = r_fcount - FCNT_ONE;
      default: w_fcount_nxt = r_fcount;
    endcase
    w_full_nxt  = (w_fcount_nxt == FCNT_FULL);
    w_empty_nxt = (w_fcount_nxt == FCNT_ZERO);
  end

  // FIFO pointers, occupancy, flags and sticky overflow.
  always_ff @(posedge in_clock or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_fcount <= FCNT_ZERO;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_fcount <= w_fcount_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge in_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr_rs, wr_data};
  end

  // Sequencer next-state and bus values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_e_nxt     = r_e;
    w_rs_nxt    = r_rs;
    w_d_nxt     = r_d;
    w_byte_nxt  = r_byte;
    w_pop       = 1'b0;
    w_cnt_zero  = (r_cnt == CNT_ZERO);
`ifdef LCD1602_4BIT_EN
    w_nib_nxt   = r_nib;
`endif
    case (r_state)
      S_IDLE: begin
        w_e_nxt = 1'b0;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_rs_nxt    = w_head[8];
          w_byte_nxt  = w_head[7:0];
          w_d_nxt     = first_lane(w_head[7:0]);
          w_cnt_nxt   = LD_SETUP;
          w_state_nxt = S_SETUP;
`ifdef LCD1602_4BIT_EN
          w_nib_nxt   = 1'b0;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_e_nxt     = 1'b1;
          w_cnt_nxt   = LD_EHI;
          w_state_nxt = S_EHI;
        end else begin
          w_e_nxt   = 1'b0;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_EHI: begin
        if (w_cnt_zero) begin
          w_e_nxt     = 1'b0;
          w_cnt_nxt   = LD_HOLD;
          w_state_nxt = S_HOLD;
        end else begin
          w_e_nxt   = 1'b1;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_HOLD: begin
        w_e_nxt = 1'b0;
        if (w_cnt_zero) begin
`ifdef LCD1602_4BIT_EN
          // High nibble done: present the low nibble with no execution wait between.
          if (!r_nib) begin
            w_nib_nxt   = 1'b1;
            w_d_nxt     = {r_byte[3:0], 4'h0};
            w_cnt_nxt   = LD_SETUP;
            w_state_nxt = S_SETUP;
          end else begin
            w_cnt_nxt   = wait_load(r_rs, r_byte);
            w_state_nxt = S_WAIT;
          end
`else
          w_cnt_nxt   = wait_load(r_rs, r_byte);
          w_state_nxt = S_WAIT;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_WAIT: begin
        w_e_nxt = 1'b0;
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_e_nxt     = 1'b0;
        w_cnt_nxt   = CNT_ZERO;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; lcd_e comes straight from r_e so it cannot glitch.
  always_ff @(posedge in_clock or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_d     <= 8'h00;
      r_byte  <= 8'h00;
      r_busy  <= 1'b0;
`ifdef LCD1602_4BIT_EN
      r_nib   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_e     <= w_e_nxt;
      r_rs    <= w_rs_nxt;
      r_d     <= w_d_nxt;
      r_byte  <= w_byte_nxt;
      r_busy  <= !((w_state_nxt == S_IDLE) && w_empty_nxt);
`ifdef LCD1602_4BIT_EN
      r_nib   <= w_nib_nxt;
`endif
    end
  end

  assign lcd_e      = r_e;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_d      = r_d;
  assign busy       = r_busy;
  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_lcd1602_writer.sv
// tb_lcd1602_writer: directed scoreboard bench for lcd1602_writer (8-bit or LCD1602_4BIT_EN build).
module tb_lcd1602_writer;

`ifdef LCD1602_4BIT_EN
  localparam int PPE = 2;
`else
  localparam int PPE = 1;
`endif

  logic       in_clock = 1'b0;
  logic       rst;
  logic       wr_stb;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_d;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         last_push_cyc = 0;
  int         idle_cyc = 0;
  int         rise_t[$];
  int         fall_t[$];
  logic [8:0] sb[$];
  logic       prev_e = 1'b0;
  logic [8:0] at_rise = 9'h000;

  lcd1602_writer dut (
    .in_clock  (in_clock),
    .rst       (rst),
    .wr_stb    (wr_stb),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_d     (lcd_d),
    .busy      (busy),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .overflow  (overflow)
  );

  always #5 in_clock = ~in_clock;

  always @(posedge in_clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] last_lane(input logic [7:0] d);
`ifdef LCD1602_4BIT_EN
    return {d[3:0], 4'h0};
`else
    return d;
`endif
  endfunction

  // Bus monitor: every E pulse is matched against the scoreboard head.
  always @(negedge in_clock) begin
    if (lcd_e === 1'b1 && prev_e === 1'b0) begin
      rise_t.push_back(cyc);
      pulses <= pulses + 1;
      at_rise <= {lcd_rs, lcd_d};
      chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("pulse_data", {lcd_rs, lcd_d}, sb.pop_front());
    end
    if (lcd_e === 1'b0 && prev_e === 1'b1 && rst === 1'b1) begin
      fall_t.push_back(cyc);
      chk("e_high_width", cyc - rise_t[$], 32'd4);
      chk("hold_data", {lcd_rs, lcd_d}, at_rise);
    end
    prev_e <= lcd_e;
  end

  task automatic push(input logic rs, input logic [7:0] d, input bit acc);
    wr_stb  = 1'b1;
    wr_rs   = rs;
    wr_data = d;
    if (acc) begin
`ifdef LCD1602_4BIT_EN
      sb.push_back({rs, d[7:4], 4'h0});
      sb.push_back({rs, d[3:0], 4'h0});
`else
      sb.push_back({rs, d});
`endif
    end
    @(negedge in_clock);
    wr_stb = 1'b0;
    last_push_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    do begin
      @(negedge in_clock);
      k++;
    end while (busy !== 1'b0 && k < budget);
    idle_cyc = cyc;
    chk(tag, busy, 32'd0);
  endtask

  initial begin
    int base;
    int p;
    int k;
    rst     = 1'b0;
    wr_stb  = 1'b0;
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    repeat (3) @(negedge in_clock);
    chk("rst_lcd_e", lcd_e, 32'd0);
    chk("rst_lcd_rs", lcd_rs, 32'd0);
    chk("rst_lcd_rw", lcd_rw, 32'd0);
    chk("rst_lcd_d", lcd_d, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_full", fifo_full, 32'd0);
    chk("rst_empty", fifo_empty, 32'd1);
    chk("rst_ovf", overflow, 32'd0);
    rst = 1'b1;
    @(negedge in_clock);

    // Single data write: E rises in the 4th cycle after the strobe cycle, busy drops 320 after HOLD.
    push(1'b1, 8'h41, 1'b1);
    p = last_push_cyc;
    chk("busy_after_push", busy, 32'd1);
    chk("empty_after_push", fifo_empty, 32'd0);
    wait_idle(1000, "idle_single");
    chk("e_latency", rise_t[0] - p, 32'd3);
    chk("busy_fall", idle_cyc - (fall_t[PPE-1] + 2), 32'd320);
    chk("idle_keeps_d", lcd_d, last_lane(8'h41));
    chk("idle_keeps_rs", lcd_rs, 32'd1);

    // Clear-display followed by data: long execution wait before the next pulse.
    base = rise_t.size();
    push(1'b0, 8'h01, 1'b1);
    push(1'b1, 8'h30, 1'b1);
    wait_idle(20000, "idle_long");
    chk("long_gap", rise_t[base+PPE] - (fall_t[base+PPE-1] + 2), 32'd13003);

    // Same code on the data port: only the normal wait.
    base = rise_t.size();
    push(1'b1, 8'h01, 1'b1);
    push(1'b1, 8'h30, 1'b1);
    wait_idle(2000, "idle_short");
    chk("short_gap", rise_t[base+PPE] - (fall_t[base+PPE-1] + 2), 32'd323);

    // Nine back-to-back writes fit because the first is popped straight away.
    base = pulses;
    for (int i = 0; i < 9; i++) push(i[0], 8'h10 + 8'(i), 1'b1);
    chk("burst9_full", fifo_full, 32'd1);
    chk("burst9_ovf", overflow, 32'd0);
    wait_idle(5000, "idle_burst9");
    chk("burst9_pulses", pulses - base, 32'(9 * PPE));
    chk("burst9_ovf_end", overflow, 32'd0);

    // Fill the FIFO while the sequencer stalls in WAIT, then overflow it.
    base = pulses;
    push(1'b1, 8'h55, 1'b1);
    repeat (40) @(negedge in_clock);
    chk("stall_started", pulses - base, 32'(PPE));
    for (int i = 0; i < 8; i++) push(1'b1, 8'h60 + 8'(i), 1'b1);
    chk("fill_full", fifo_full, 32'd1);
    chk("fill_ovf", overflow, 32'd0);
    push(1'b1, 8'h7f, 1'b0);
    chk("drop_sets_ovf", overflow, 32'd1);
    chk("drop_keeps_full", fifo_full, 32'd1);
    clr_ovf = 1'b1;
    push(1'b0, 8'h7e, 1'b0);
    clr_ovf = 1'b0;
    chk("drop_and_clr_set", overflow, 32'd1);
    clr_ovf = 1'b1;
    @(negedge in_clock);
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 32'd0);
    clr_ovf = 1'b1;
    push(1'b0, 8'h7d, 1'b0);
    clr_ovf = 1'b0;
    chk("drop_beats_clr", overflow, 32'd1);
    clr_ovf = 1'b1;
    @(negedge in_clock);
    clr_ovf = 1'b0;
    chk("clr_ovf_again", overflow, 32'd0);
    wait_idle(5000, "idle_fill");
    chk("fill_pulses", pulses - base, 32'(9 * PPE));

`ifdef LCD1602_4BIT_EN
    // Nibble mode: two pulses, four cycles apart, one wait after the low nibble.
    base = rise_t.size();
    push(1'b1, 8'ha5, 1'b1);
    wait_idle(1000, "idle_nibble");
    chk("nibble_pulses", rise_t.size() - base, 32'd2);
    chk("nibble_gap", rise_t[base+1] - fall_t[base], 32'd4);
    chk("nibble_wait", idle_cyc - (fall_t[base+1] + 2), 32'd320);
    chk("nibble_low_zero", lcd_d[3:0], 32'd0);
`endif

    chk("sb_drained", sb.size(), 32'd0);

    // Reset in the middle of the E-high phase with a second entry still queued.
    push(1'b1, 8'h77, 1'b1);
    push(1'b1, 8'h78, 1'b1);
    k = 0;
    while (lcd_e !== 1'b1 && k < 100) begin
      @(negedge in_clock);
      k++;
    end
    chk("reached_ehi", lcd_e, 32'd1);
    @(posedge in_clock);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_e", lcd_e, 32'd0);
    sb.delete();
    repeat (3) @(negedge in_clock);
    rst = 1'b1;
    @(negedge in_clock);
    chk("post_rst_empty", fifo_empty, 32'd1);
    chk("post_rst_busy", busy, 32'd0);
    p = pulses;
    repeat (400) @(negedge in_clock);
    chk("post_rst_no_pulse", pulses - p, 32'd0);
    chk("post_rst_idle", busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
